// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, FSM states, opcode/funct constants, ALU codes and datapath mux encodings.
package cpu_pkg;
  localparam int OP_W = 6;
  localparam int FUNCT_W = 6;
  localparam int ALU_CTRL_W = 4;
  localparam int SRC_B_W = 3;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [FUNCT_W-1:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_A = 2'b01, SRCA_B = 2'b10;
  localparam logic [SRC_B_W-1:0] SRCB_B = 3'b000, SRCB_4 = 3'b001, SRCB_IMM = 3'b010, SRCB_IMM_SH = 3'b011, SRCB_SHAMT = 3'b100;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  function automatic logic is_i_alu(input logic [OP_W-1:0] op);
    return op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: (opcode, funct) -> ALU control code, shift operand select, zero-extend flag, legality.
module alu_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]       opcode,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  shift,
  output logic                  ext_zero,
  output logic                  legal
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    shift = 1'b0;
    ext_zero = 1'b0;
    legal = 1'b1;
    if (opcode == OP_RTYPE)
      case (funct)
        F_ADD: alu_ctrl = ALU_ADD;
        F_SUB: alu_ctrl = ALU_SUB;
        F_AND: alu_ctrl = ALU_AND;
        F_OR:  alu_ctrl = ALU_OR;
        F_XOR: alu_ctrl = ALU_XOR;
        F_NOR: alu_ctrl = ALU_NOR;
        F_SLT: alu_ctrl = ALU_SLT;
        F_SLL: begin alu_ctrl = ALU_SLL; shift = 1'b1; end
        F_SRL: begin alu_ctrl = ALU_SRL; shift = 1'b1; end
        F_SRA: begin alu_ctrl = ALU_SRA; shift = 1'b1; end
        default: legal = 1'b0;
      endcase
    else
      case (opcode)
        OP_ADDI: alu_ctrl = ALU_ADD;
        OP_SLTI: alu_ctrl = ALU_SLT;
        OP_ANDI: begin alu_ctrl = ALU_AND; ext_zero = 1'b1; end
        OP_ORI:  begin alu_ctrl = ALU_OR;  ext_zero = 1'b1; end
        OP_XORI: begin alu_ctrl = ALU_XOR; ext_zero = 1'b1; end
        default: legal = 1'b0;
      endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with sticky illegal-op trap.
// Define MC_CTRL_MEM_WAIT_EN to add mem_ready and stall the memory states on it.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [OP_W-1:0]       opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic [1:0]            ALUSrcA,
  output logic [SRC_B_W-1:0]    ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  ExtZero,
  output logic                  IorD,
  output logic [1:0]            PCSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  illegal_op
);
  state_t state, nxt;
  logic ready, go, ir_w, pc_w, reg_w, mem_r, mem_w;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic shift, ext_zero, legal;
`ifdef MC_CTRL_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif
  alu_decode u_dec (.opcode(opcode), .funct(funct), .alu_ctrl(alu_ctrl), .shift(shift), .ext_zero(ext_zero), .legal(legal));
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:    nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = opcode == OP_RTYPE ? S_EXEC_R :
                        is_i_alu(opcode) ? S_EXEC_I :
                        (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                        (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                        opcode == OP_J ? S_JUMP : S_TRAP;
      S_EXEC_R:   nxt = legal ? S_ALU_WB : S_TRAP;
      S_EXEC_I:   nxt = S_ALU_WB;
      S_MEM_ADDR: nxt = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = ready ? S_FETCH : S_MEM_WR;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      illegal_op <= 1'b0;
    end else if (clk_en) begin
      state <= nxt;
      illegal_op <= illegal_op | (nxt == S_TRAP);
    end
  // Raw strobes are decoded here and gated by clk_en/rst below, so a frozen or aborted cycle never writes.
  always_comb begin
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_B;
    ALUControl = ALU_ADD;
    ExtZero = 1'b0;
    IorD = 1'b0;
    PCSrc = PC_ALU;
    RegDst = 1'b0;
    MemToReg = 1'b0;
    ir_w = 1'b0;
    pc_w = 1'b0;
    reg_w = 1'b0;
    mem_r = 1'b0;
    mem_w = 1'b0;
    case (state)
      S_FETCH:    begin ALUSrcB = SRCB_4; mem_r = 1'b1; ir_w = ready; pc_w = ready; end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH;
      S_EXEC_R:   begin ALUSrcA = shift ? SRCA_B : SRCA_A; ALUSrcB = shift ? SRCB_SHAMT : SRCB_B; ALUControl = alu_ctrl; end
      S_EXEC_I:   begin ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ALUControl = alu_ctrl; ExtZero = ext_zero; end
      S_ALU_WB:   begin reg_w = 1'b1; RegDst = opcode == OP_RTYPE; end
      S_MEM_ADDR: begin ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; end
      S_MEM_RD:   begin IorD = 1'b1; mem_r = 1'b1; end
      S_MEM_WB:   begin reg_w = 1'b1; MemToReg = 1'b1; end
      S_MEM_WR:   begin IorD = 1'b1; mem_w = 1'b1; end
      S_BRANCH:   begin ALUSrcA = SRCA_A; ALUControl = ALU_SUB; PCSrc = PC_ALUOUT; pc_w = (opcode == OP_BNE) ^ zero; end
      S_JUMP:     begin PCSrc = PC_JUMP; pc_w = 1'b1; end
      default:    ;
    endcase
  end
  assign go = clk_en & ~rst;
  assign IRWrite = ir_w & go;
  assign PCWrite = pc_w & go;
  assign RegWrite = reg_w & go;
  assign MemRead = mem_r & go;
  assign MemWrite = mem_w & go;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; each queue entry holds one cycle's stimulus and the expected outputs.
module tb_multicycle_ctrl;
  import cpu_pkg::*;
  logic clk, rst, clk_en, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic [1:0] ALUSrcA, PCSrc;
  logic [2:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic ExtZero, IorD, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, RegDst, MemToReg, illegal_op;
  logic [20:0] obs;
  int passed = 0, total = 0;
  typedef struct {
    string n;
    logic en, rdy, rs, z;
    logic [20:0] m, v;
  } exp_t;
  exp_t q[$];

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ExtZero(ExtZero), .IorD(IorD),
    .PCSrc(PCSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .MemToReg(MemToReg), .illegal_op(illegal_op)
  );

  // [20:19] SrcA [18:16] SrcB [15:12] ALU [11] ExtZero [10] IorD [9:8] PCSrc [7:3] IRW,PCW,RW,MR,MW [2] RegDst [1] MemToReg [0] illegal
  assign obs = {ALUSrcA, ALUSrcB, ALUControl, ExtZero, IorD, PCSrc, IRWrite, PCWrite,
                RegWrite, MemRead, MemWrite, RegDst, MemToReg, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input logic ill = 1'b0);
    exp_t e;
    e.n = n; e.en = 1'b1; e.rdy = 1'b1; e.rs = 1'b0; e.z = 1'b0;
    e.m = 21'h0000F9; e.v = '0; e.v[0] = ill;
    return e;
  endfunction
  function automatic exp_t e_fetch(input logic ill = 1'b0);
    exp_t e = mk("fetch", ill);
    e.m[20:12] = '1; e.v[20:12] = {2'b00, 3'b001, ALU_ADD};
    e.m[10:8] = '1;
    e.v[7] = 1'b1; e.v[6] = 1'b1; e.v[4] = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_alu3(input string n, input logic [1:0] a, input logic [2:0] b, input logic [3:0] alu);
    exp_t e = mk(n);
    e.m[20:12] = '1; e.v[20:12] = {a, b, alu};
    return e;
  endfunction
  function automatic exp_t e_exec_i(input logic [3:0] alu, input logic ext);
    exp_t e = e_alu3("exec_i", 2'b01, 3'b010, alu);
    e.m[11] = 1'b1; e.v[11] = ext;
    return e;
  endfunction
  function automatic exp_t e_wb(input string n, input logic rd, input logic m2r);
    exp_t e = mk(n);
    e.m[2:1] = '1; e.v[2:1] = {rd, m2r}; e.v[5] = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_mem(input string n, input logic wr);
    exp_t e = mk(n);
    e.m[10] = 1'b1; e.v[10] = 1'b1;
    if (wr) e.v[3] = 1'b1; else e.v[4] = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_branch(input logic z, input logic pcw);
    exp_t e = e_alu3("branch", 2'b01, 3'b000, ALU_SUB);
    e.m[9:8] = '1; e.v[9:8] = 2'b01; e.v[6] = pcw; e.z = z;
    return e;
  endfunction

  task automatic push(input exp_t e);
    if (!e.en || e.rs) e.v[7:3] = '0;
    q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    e = mk("rst0"); e.rs = 1'b1; push(e);
    e = mk("rst1"); e.rs = 1'b1; push(e);
    e = e_fetch(); e.n = "fetch_en0"; e.en = 1'b0; push(e);
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL reset/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_r_type();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      opcode = 6'h00; funct = i == 0 ? 6'h20 : 6'h03;
      push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
      push(i == 0 ? e_alu3("exec_r_add", 2'b01, 3'b000, ALU_ADD) : e_alu3("exec_r_sra", 2'b10, 3'b100, ALU_SRA));
      push(e_wb("alu_wb_r", 1'b1, 1'b0));
      while (q.size() > 0) begin
        e = q.pop_front();
        rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
        #1; total++;
        if ((obs & e.m) !== e.v) $display("FAIL r_type/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_i_type();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      opcode = i == 0 ? 6'h0D : 6'h08; funct = 6'h3F;
      push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
      push(i == 0 ? e_exec_i(ALU_OR, 1'b1) : e_exec_i(ALU_ADD, 1'b0));
      push(e_wb("alu_wb_i", 1'b0, 1'b0));
      while (q.size() > 0) begin
        e = q.pop_front();
        rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
        #1; total++;
        if ((obs & e.m) !== e.v) $display("FAIL i_type/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mem();
    exp_t e;
    opcode = 6'h23; funct = 6'h00;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    push(e_alu3("mem_addr_lw", 2'b01, 3'b010, ALU_ADD));
`ifdef MC_CTRL_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin e = e_mem("mem_rd_wait", 1'b0); e.rdy = 1'b0; push(e); end
`endif
    push(e_mem("mem_rd", 1'b0)); push(e_wb("mem_wb", 1'b0, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL lw/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
    opcode = 6'h2B;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    push(e_alu3("mem_addr_sw", 2'b01, 3'b010, ALU_ADD)); push(e_mem("mem_wr", 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL sw/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    logic [5:0] ops [4] = '{6'h04, 6'h04, 6'h05, 6'h02};
    logic zs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic pcws [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
      if (i == 3) begin
        e = mk("jump"); e.m[9:8] = '1; e.v[9:8] = 2'b10; e.v[6] = 1'b1; e.z = zs[i]; push(e);
      end else push(e_branch(zs[i], pcws[i]));
      while (q.size() > 0) begin
        e = q.pop_front();
        rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
        #1; total++;
        if ((obs & e.m) !== e.v) $display("FAIL branch_jump[%0d]/%s: got %h want %h (mask %h)", i, e.n, obs & e.m, e.v, e.m);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_clk_en();
    exp_t e;
    opcode = 6'h00; funct = 6'h22;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    for (int i = 0; i < 5; i++) begin e = e_alu3("exec_r_frozen", 2'b01, 3'b000, ALU_SUB); e.en = 1'b0; push(e); end
    push(e_alu3("exec_r_sub", 2'b01, 3'b000, ALU_SUB));
    e = e_wb("alu_wb_frozen", 1'b1, 1'b0); e.en = 1'b0; push(e);
    push(e_wb("alu_wb", 1'b1, 1'b0));
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL clk_en/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    opcode = 6'h2B;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    push(e_alu3("mem_addr", 2'b01, 3'b010, ALU_ADD));
    e = e_mem("mem_wr_rst", 1'b1); e.rs = 1'b1; push(e);
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL rst_mid/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    exp_t e;
    opcode = 6'h00; funct = 6'h3F;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    e = e_alu3("exec_r_bad", 2'b01, 3'b000, ALU_ADD); e.m[15:12] = '0; push(e);
    push(mk("trap_funct", 1'b1));
    e = mk("trap_en0", 1'b1); e.en = 1'b0; push(e);
    e = mk("trap_rst", 1'b1); e.rs = 1'b1; push(e);
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL trap_funct/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
    opcode = 6'h3F; funct = 6'h20;
    push(e_fetch()); push(e_alu3("decode", 2'b00, 3'b011, ALU_ADD));
    push(mk("trap_op", 1'b1)); push(mk("trap_hold", 1'b1));
    e = mk("trap_rst2", 1'b1); e.rs = 1'b1; push(e);
    push(e_fetch());
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.rs; clk_en = e.en; mem_ready = e.rdy; zero = e.z;
      #1; total++;
      if ((obs & e.m) !== e.v) $display("FAIL trap_op/%s: got %h want %h (mask %h)", e.n, obs & e.m, e.v, e.m);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0;
    @(negedge clk);
    test_reset();
    test_r_type();
    test_i_type();
    test_mem();
    test_branch_jump();
    test_clk_en();
    test_rst_mid();
    test_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
